// File: rtl/usb_rx_packet_sequencer.sv
// rtl/usb_rx_packet_sequencer.sv - USB RX packet sequencer: PID check, CRC16 strip, LE word packing
// Bytes pass a 2-deep pipe so the trailing CRC never reaches the word assembler.
module usb_rx_packet_sequencer #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             receiving,
  input  logic             write_enable,
  input  logic [7:0]       rx_data,
  input  logic             rcv_error,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [31:0]      word_data,
  output logic [3:0]       word_be,
  output logic             word_last,
  output logic [3:0]       pid,
  output logic             pid_valid,
  output logic             pkt_done,
  output logic             pkt_abort,
  output logic             overflow,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE, PID, PAYLOAD, FLUSH, DONE, ABORT, WAIT_END
  } state_t;

  state_t             state_q;
  logic [7:0]         pipe0_q, pipe1_q;
  logic [1:0]         pipe_cnt_q;
  logic [31:0]        asm_q;
  logic [2:0]         asm_cnt_q;
  logic               word_valid_q, word_last_q;
  logic [31:0]        word_data_q;
  logic [3:0]         word_be_q;
  logic [3:0]         pid_q;
  logic               pid_valid_q, pkt_done_q, pkt_abort_q, overflow_q;
  logic [CNT_W-1:0]   byte_count_q;
  logic               out_free;
  logic [3:0]         flush_be_d;

  assign out_free = !word_valid_q || word_ready;

  always_comb begin
    flush_be_d = 4'hF;
    case (asm_cnt_q)
      3'd1:    flush_be_d = 4'h1;
      3'd2:    flush_be_d = 4'h3;
      3'd3:    flush_be_d = 4'h7;
      default: flush_be_d = 4'hF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pipe0_q      <= 8'h00;
      pipe1_q      <= 8'h00;
      pipe_cnt_q   <= 2'd0;
      asm_q        <= 32'h0;
      asm_cnt_q    <= 3'd0;
      word_valid_q <= 1'b0;
      word_data_q  <= 32'h0;
      word_be_q    <= 4'h0;
      word_last_q  <= 1'b0;
      pid_q        <= 4'h0;
      pid_valid_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_abort_q  <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      pid_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
      if (word_valid_q && word_ready) word_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (receiving) state_q <= PID;
        PID: begin
          if (rcv_error) begin
            state_q     <= ABORT;
            pkt_abort_q <= 1'b1;
          end else if (write_enable) begin
            if (rx_data[3:0] == ~rx_data[7:4]) begin
              pid_q        <= rx_data[3:0];
              pid_valid_q  <= 1'b1;
              overflow_q   <= 1'b0;
              byte_count_q <= '0;
              pipe_cnt_q   <= 2'd0;
              asm_q        <= 32'h0;
              asm_cnt_q    <= 3'd0;
              state_q      <= PAYLOAD;
            end else begin
              state_q     <= ABORT;
              pkt_abort_q <= 1'b1;
            end
          end else if (!receiving) begin
            state_q     <= ABORT;
            pkt_abort_q <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (rcv_error) begin
            state_q     <= ABORT;
            pkt_abort_q <= 1'b1;
          end else if (write_enable) begin
            pipe0_q <= rx_data;
            pipe1_q <= pipe0_q;
            if (pipe_cnt_q != 2'd2) begin
              pipe_cnt_q <= pipe_cnt_q + 2'd1;
            end else if (byte_count_q == CNT_W'(MAX_BYTES) ||
                         (asm_cnt_q == 3'd4 && !out_free)) begin
              overflow_q  <= 1'b1;
              state_q     <= ABORT;
              pkt_abort_q <= 1'b1;
            end else begin
              byte_count_q <= byte_count_q + CNT_W'(1);
              // A full word leaves only when the next byte proves it is not the last one.
              if (asm_cnt_q == 3'd4) begin
                word_valid_q <= 1'b1;
                word_data_q  <= asm_q;
                word_be_q    <= 4'hF;
                word_last_q  <= 1'b0;
                asm_q        <= {24'h0, pipe1_q};
                asm_cnt_q    <= 3'd1;
              end else begin
                asm_q[{asm_cnt_q[1:0], 3'b000} +: 8] <= pipe1_q;
                asm_cnt_q <= asm_cnt_q + 3'd1;
              end
            end
          end else if (!receiving) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (rcv_error) begin
            state_q     <= ABORT;
            pkt_abort_q <= 1'b1;
          end else if (asm_cnt_q == 3'd0) begin
            state_q    <= DONE;
            pkt_done_q <= 1'b1;
          end else if (out_free) begin
            word_valid_q <= 1'b1;
            word_data_q  <= asm_q;
            word_be_q    <= flush_be_d;
            word_last_q  <= 1'b1;
            asm_q        <= 32'h0;
            asm_cnt_q    <= 3'd0;
            state_q      <= DONE;
            pkt_done_q   <= 1'b1;
          end
        end
        DONE: begin
          pipe_cnt_q <= 2'd0;
          state_q    <= IDLE;
        end
        ABORT: begin
          pipe_cnt_q   <= 2'd0;
          asm_q        <= 32'h0;
          asm_cnt_q    <= 3'd0;
          byte_count_q <= '0;
          state_q      <= WAIT_END;
        end
        WAIT_END: if (!receiving) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign word_be    = word_be_q;
  assign word_last  = word_last_q;
  assign pid        = pid_q;
  assign pid_valid  = pid_valid_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_abort  = pkt_abort_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule
